// File: rtl/ternary_trit_deserializer_pkg.sv
// Shared trit encoding, FSM state type and width helper for the ternary datapath blocks.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_0   = 2'b00;
  localparam trit_t TRIT_1   = 2'b01;
  localparam trit_t TRIT_2   = 2'b10;
  localparam trit_t TRIT_INV = 2'b11;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Smallest w with 2^w >= 3^n, i.e. enough bits for the largest n-trit value 3^n-1.
  function automatic int unsigned trit_width(input int unsigned n);
    longint unsigned p;
    int unsigned     w;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd3;
    end
    w = 0;
    while (w < 64 && (64'd1 << w) < p) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/ternary_trit_deserializer_if.sv
// Trit input and word output handshakes of the ternary deserializer.
interface ternary_trit_deserializer_if #(
  parameter int unsigned W = 8
);
  import ternary_pkg::*;

  logic           in_valid;
  logic           in_ready;
  trit_t          in_trit;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_value;
  logic           out_err;

  modport master (
    output in_valid, in_trit, out_ready,
    input  in_ready, out_valid, out_value, out_err
  );

  modport slave (
    input  in_valid, in_trit, out_ready,
    output in_ready, out_valid, out_value, out_err
  );

endinterface

// File: rtl/ternary_trit_deserializer_decode.sv
// Combinational trit decoder: 2-bit code to digit 0..2, invalid code reads as digit 0.
module ternary_trit_decode
  import ternary_pkg::*;
(
  input  trit_t      trit,
  output logic [1:0] digit,
  output logic       invalid
);

  always_comb begin
    digit   = 2'd0;
    invalid = 1'b0;
    case (trit)
      TRIT_0:   digit = 2'd0;
      TRIT_1:   digit = 2'd1;
      TRIT_2:   digit = 2'd2;
      default:  invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/ternary_trit_deserializer.sv
// Serial MSB-first trit stream to unsigned binary word, valid/ready on both sides.
// Optional TERNARY_DESER_OVERLAP_EN lets the first trit of the next word enter during the output handshake.
module ternary_trit_deserializer
  import ternary_pkg::*;
#(
  parameter int unsigned TRITS = 5,
  parameter int unsigned W     = 8
)(
  input logic                      clk,
  input logic                      rst,
  ternary_trit_deserializer_if.slave bus
);

  localparam int unsigned CW = (TRITS > 1) ? $clog2(TRITS) : 1;

  if (TRITS < 1) begin : g_trits_check
    $error("ternary_trit_deserializer: TRITS must be >= 1");
  end
  if (W < trit_width(TRITS)) begin : g_width_check
    $error("ternary_trit_deserializer: W too small for 3^TRITS-1");
  end

  state_t          state;
  logic [W-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic            err;
  logic [W-1:0]    out_value_r;
  logic            out_err_r;

  logic [1:0]      digit;
  logic            invalid;
  logic            in_ready;
  logic            accept;
  logic            out_fire;
  logic [W-1:0]    base_acc;
  logic [CW-1:0]   base_cnt;
  logic            base_err;
  logic [W-1:0]    acc_step;
  logic            err_step;
  logic            last;

  ternary_trit_decode u_decode (
    .trit    (bus.in_trit),
    .digit   (digit),
    .invalid (invalid)
  );

  always_comb begin
`ifdef TERNARY_DESER_OVERLAP_EN
    in_ready = (state == COLLECT) || bus.out_ready;
`else
    in_ready = (state == COLLECT);
`endif
    out_fire = (state == HOLD) && bus.out_ready;
    accept   = bus.in_valid && in_ready;
    // A trit taken during the output handshake starts from an empty word.
    base_acc = out_fire ? '0   : acc;
    base_cnt = out_fire ? '0   : cnt;
    base_err = out_fire ? 1'b0 : err;
    acc_step = (base_acc << 1) + base_acc + W'(digit);
    err_step = base_err | invalid;
    last     = (base_cnt == CW'(TRITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      acc         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      out_value_r <= '0;
      out_err_r   <= 1'b0;
    end else begin
      if (out_fire) begin
        state <= COLLECT;
        acc   <= '0;
        cnt   <= '0;
        err   <= 1'b0;
      end
      if (accept) begin
        if (last) begin
          state       <= HOLD;
          out_value_r <= acc_step;
          out_err_r   <= err_step;
        end else begin
          acc <= acc_step;
          cnt <= base_cnt + CW'(1);
          err <= err_step;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_value = out_value_r;
  assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_ternary_trit_deserializer.sv
// Directed self-checking bench for ternary_trit_deserializer (TRITS=5, W=8).
module tb_ternary_trit_deserializer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ternary_trit_deserializer_if #(.W(8)) bus ();

  ternary_trit_deserializer #(.TRITS(5), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drives five trits back-to-back, returns at the negedge one cycle after the last accept.
  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_trit  = w[9-2*i -: 2];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_trit   = 2'b00;
    bus.out_ready = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_value !== 8'd0) begin failures++; $display("FAIL reset_out_value got=%0d exp=0", bus.out_value); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [9:0] w;
    logic       exp_rdy;
    w = 10'b10_01_00_10_01;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid trit=%0d got=%b exp=0", i, bus.out_valid); end
      bus.in_valid = 1'b1;
      bus.in_trit  = w[9-2*i -: 2];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef TERNARY_DESER_OVERLAP_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_value !== 8'd196) begin failures++; $display("FAIL basic_value got=%0d exp=196", bus.out_value); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", bus.out_err); end
    checks++; if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL basic_hold_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_single_word got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_patterns();
    bus.out_ready = 1'b1;
    send_word(10'b10_10_10_10_10);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL all2_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_value !== 8'd242) begin failures++; $display("FAIL all2_value got=%0d exp=242", bus.out_value); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL all2_err got=%b exp=0", bus.out_err); end
    @(negedge clk);
    send_word(10'b00_00_00_00_00);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL all0_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_value !== 8'd0) begin failures++; $display("FAIL all0_value got=%0d exp=0", bus.out_value); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL all0_err got=%b exp=0", bus.out_err); end
    @(negedge clk);
  endtask

  task automatic test_error();
    bus.out_ready = 1'b1;
    send_word(10'b01_01_11_01_01);
    checks++; if (bus.out_value !== 8'd112) begin failures++; $display("FAIL err_word_value got=%0d exp=112", bus.out_value); end
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL err_word_flag got=%b exp=1", bus.out_err); end
    @(negedge clk);
    send_word(10'b00_00_00_00_01);
    checks++; if (bus.out_value !== 8'd1) begin failures++; $display("FAIL err_clear_value got=%0d exp=1", bus.out_value); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL err_clear_flag got=%b exp=0", bus.out_err); end
    @(negedge clk);
  endtask

  task automatic test_hold_stall();
    bus.out_ready = 1'b0;
    send_word(10'b10_01_00_10_01);
    // Offered trits must not be absorbed while the word is held.
    bus.in_valid = 1'b1;
    bus.in_trit  = 2'b10;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", k, bus.out_valid); end
      checks++; if (bus.out_value !== 8'd196) begin failures++; $display("FAIL stall_value cyc=%0d got=%0d exp=196", k, bus.out_value); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", k, bus.in_ready); end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", bus.out_valid); end
    send_word(10'b00_00_00_00_00);
    checks++; if (bus.out_value !== 8'd0) begin failures++; $display("FAIL stall_no_absorb got=%0d exp=0", bus.out_value); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_trit  = 2'b10;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    send_word(10'b00_00_00_01_10);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_word_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_value !== 8'd5) begin failures++; $display("FAIL midrst_residue got=%0d exp=5", bus.out_value); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_word(10'b10_10_10_10_10);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL holdrst_pre got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL holdrst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_value !== 8'd0) begin failures++; $display("FAIL holdrst_value got=%0d exp=0", bus.out_value); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] stream [10];
    int         idx;
    int         words;
    int         cyc_w [2];
    logic [7:0] val_w [2];
    int         exp_gap;
    stream = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0};
`ifdef TERNARY_DESER_OVERLAP_EN
    exp_gap = 5;
`else
    exp_gap = 6;
`endif
    idx   = 0;
    words = 0;
    cyc_w = '{0, 0};
    val_w = '{8'd0, 8'd0};
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 30 && words < 2; cyc++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        cyc_w[words] = cyc;
        val_w[words] = bus.out_value;
        words++;
      end
      if (idx < 10) begin
        bus.in_valid = 1'b1;
        bus.in_trit  = stream[idx];
        if (bus.in_ready === 1'b1) idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (words !== 2) begin failures++; $display("FAIL b2b_words got=%0d exp=2", words); end
    checks++; if (idx !== 10) begin failures++; $display("FAIL b2b_accepts got=%0d exp=10", idx); end
    checks++; if (val_w[0] !== 8'd196) begin failures++; $display("FAIL b2b_word0 got=%0d exp=196", val_w[0]); end
    checks++; if (val_w[1] !== 8'd105) begin failures++; $display("FAIL b2b_word1 got=%0d exp=105", val_w[1]); end
    checks++; if (cyc_w[0] !== 6) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=6", cyc_w[0]); end
    checks++; if (cyc_w[1] - cyc_w[0] !== exp_gap) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", cyc_w[1] - cyc_w[0], exp_gap); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_patterns();
    test_error();
    test_hold_stall();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
